ube_pwrseq: RTL and testbench
=============================

Name: ube_pwrseq

Overview:
- Unibus Exerciser power-fail sequencer, directly downstream of UBE control/status register #2.
- Consumes the CSR2 ACLO bit (bit 4) and generates timed Unibus ACLO/DCLO sequencing toward the UBA.
- Raises power-fail and power-up interrupt requests with a req/ack handshake, so diagnostics can emulate a power failure and recovery under software control.

Parameters:
- ACLO_DLY, 16'd100: clocks from ACLO assertion to DCLO assertion; legal range 1..65535.
- DCLO_MIN, 16'd50: minimum clocks DCLO stays asserted; legal range 1..65535.
- RECOVER_DLY, 16'd100: clocks from DCLO negation to ACLO negation; legal range 1..65535.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- devRESET  in  1  Unibus INIT; synchronous, same effect as rst
- csr2ACLO  in  1  CSR2 bit 4 (regCSR2[4]); level request for power failure
- intACK  in  1  interrupt acknowledge from the UBE interrupt logic; one-clock pulse
- ubeACLO  out  1  Unibus AC LO to UBA
- ubeDCLO  out  1  Unibus DC LO to UBA
- intREQ  out  1  interrupt request; level, held until acknowledged
- intPWRUP  out  1  request type, valid while intREQ=1: 0=power-fail, 1=power-up
- overrun  out  1  sticky flag: an event occurred while intREQ was pending
- busy  out  1  1 whenever the state is not IDLE

Behaviour:
- Reset (rst or devRESET): state=IDLE, counter=0, and all outputs = 0. This applies from any state, mid-sequence included; no interrupt is generated by reset.
- 16-bit down-counter cnt, loaded on every state entry, decremented each clock, terminal when cnt==1. A delay of N therefore gives exactly N clocks in the state.
- IDLE (ACLO=0, DCLO=0): csr2ACLO=1 -> ACLO_WAIT with cnt=ACLO_DLY, and the power-fail event fires.
- ACLO_WAIT (ACLO=1, DCLO=0):
  - csr2ACLO=0 -> RECOVER with cnt=RECOVER_DLY. This is an aborted failure; DCLO is never asserted.
  - Otherwise terminal count -> DCLO_HOLD with cnt=DCLO_MIN.
- DCLO_HOLD (ACLO=1, DCLO=1): leave only when the count has expired AND csr2ACLO=0, then go to RECOVER with cnt=RECOVER_DLY. Once cnt reaches 1 it stays at 1.
- RECOVER (ACLO=1, DCLO=0):
  - csr2ACLO=1 -> ACLO_WAIT with cnt=ACLO_DLY; a new power-fail event fires.
  - Otherwise terminal count -> IDLE, and the power-up event fires.
- ubeACLO and ubeDCLO are registered, so they change on the clock edge that enters the new state: one clock of latency from the csr2ACLO edge to ubeACLO rising.
- Events and the interrupt handshake:
  - An event with intREQ=0 sets intREQ=1 on the next edge, with intPWRUP = event type.
  - An event with intREQ=1 leaves intREQ and intPWRUP unchanged and sets overrun=1.
  - intACK=1 while intREQ=1 clears intREQ on the next edge. intACK while intREQ=0 is ignored.
  - If intACK and an event arrive on the same clock, the ack is taken first: intREQ stays 1 and intPWRUP takes the new event's type. overrun is not set.
  - overrun is cleared only by rst or devRESET.
- busy = (state != IDLE), registered with the state.

Optional Feature:
- Macro: UBE_PWRUP_INT_EN.
- Defined: the power-up event on the RECOVER->IDLE transition raises an interrupt with intPWRUP=1, as described above.
- Undefined: the power-up event is suppressed. It neither sets intREQ nor sets overrun, and intPWRUP is tied to 0. Power-fail interrupts are unchanged.

Test Plan:
- Full sequence (ACLO_DLY=4, DCLO_MIN=3, RECOVER_DLY=5):
  - Raise csr2ACLO at cycle 0 -> ubeACLO=1 at cycle 1 and intREQ=1, intPWRUP=0 at cycle 1.
  - ubeDCLO=1 at cycle 5.
  - Drop csr2ACLO at cycle 20 -> ubeDCLO=0 at cycle 21, ubeACLO=0 at cycle 26.
  - With intACK pulsed at cycle 10: intREQ=1, intPWRUP=1 at cycle 26 (macro defined).
- Abort: csr2ACLO high for cycles 0-1 only -> ubeDCLO never asserts, ubeACLO falls 5 clocks after RECOVER entry, busy=0 afterwards.
- Minimum DCLO: csr2ACLO pulse ending while in DCLO_HOLD at its first cycle -> ubeDCLO stays high exactly 3 clocks.
- Overrun: no intACK while power-fail then power-up events occur -> intREQ stays 1 with intPWRUP=0, and overrun=1.
- Reset mid-operation: devRESET asserted in DCLO_HOLD -> next edge all outputs 0, busy=0, no interrupt afterwards.
- Macro undefined: repeat the full sequence -> only the power-fail interrupt occurs; intPWRUP stays 0 and overrun stays 0.

Source files
------------

// File: rtl/ube_pwrseq.sv
// Unibus Exerciser power-fail sequencer: CSR2 ACLO request -> timed ubeACLO/ubeDCLO plus interrupt req/ack.
// Optional macro UBE_PWRUP_INT_EN enables the power-up interrupt on RECOVER->IDLE.
module ube_pwrseq #(
  parameter logic [15:0] ACLO_DLY    = 16'd100,
  parameter logic [15:0] DCLO_MIN    = 16'd50,
  parameter logic [15:0] RECOVER_DLY = 16'd100
) (
  input  logic clk,
  input  logic rst,
  input  logic devRESET,
  input  logic csr2ACLO,
  input  logic intACK,
  output logic ubeACLO,
  output logic ubeDCLO,
  output logic intREQ,
  output logic intPWRUP,
  output logic overrun,
  output logic busy
);

  typedef enum logic [1:0] {IDLE, ACLO_WAIT, DCLO_HOLD, RECOVER} state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        srst;
  logic        terminal;
  logic        ev;
  logic        take_ev;
`ifdef UBE_PWRUP_INT_EN
  logic        ev_pwrup;
`endif

  assign srst     = rst | devRESET;
  assign terminal = (cnt == 16'd1);
  // An ack on the same clock frees the request slot for the new event.
  assign take_ev  = ev & (~intREQ | intACK);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt > 16'd1) ? cnt - 16'd1 : cnt;
    ev        = 1'b0;
`ifdef UBE_PWRUP_INT_EN
    ev_pwrup  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (csr2ACLO) begin
          state_nxt = ACLO_WAIT;
          cnt_nxt   = ACLO_DLY;
          ev        = 1'b1;
        end
      end
      ACLO_WAIT: begin
        if (!csr2ACLO) begin
          state_nxt = RECOVER;
          cnt_nxt   = RECOVER_DLY;
        end else if (terminal) begin
          state_nxt = DCLO_HOLD;
          cnt_nxt   = DCLO_MIN;
        end
      end
      DCLO_HOLD: begin
        if (terminal && !csr2ACLO) begin
          state_nxt = RECOVER;
          cnt_nxt   = RECOVER_DLY;
        end
      end
      RECOVER: begin
        if (csr2ACLO) begin
          state_nxt = ACLO_WAIT;
          cnt_nxt   = ACLO_DLY;
          ev        = 1'b1;
        end else if (terminal) begin
          state_nxt = IDLE;
          cnt_nxt   = 16'd0;
`ifdef UBE_PWRUP_INT_EN
          ev        = 1'b1;
          ev_pwrup  = 1'b1;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state   <= IDLE;
      cnt     <= 16'd0;
      ubeACLO <= 1'b0;
      ubeDCLO <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ubeACLO <= (state_nxt != IDLE);
      ubeDCLO <= (state_nxt == DCLO_HOLD);
      busy    <= (state_nxt != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      intREQ  <= 1'b0;
      overrun <= 1'b0;
    end else if (ev) begin
      if (take_ev) intREQ  <= 1'b1;
      else         overrun <= 1'b1;
    end else if (intACK) begin
      intREQ <= 1'b0;
    end
  end

`ifdef UBE_PWRUP_INT_EN
  always_ff @(posedge clk) begin
    if (srst)         intPWRUP <= 1'b0;
    else if (take_ev) intPWRUP <= ev_pwrup;
  end
`else
  assign intPWRUP = 1'b0;
`endif

endmodule

// File: tb/tb_ube_pwrseq.sv
// Scoreboard bench for ube_pwrseq: per-cycle expected output vectors queued at drive time, compared after the edge.
// Vector order: {ubeACLO, ubeDCLO, intREQ, intPWRUP, overrun, busy}.
module tb_ube_pwrseq;

`ifdef UBE_PWRUP_INT_EN
  localparam bit PW = 1'b1;
`else
  localparam bit PW = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, devRESET, csr2ACLO, intACK;
  logic ubeACLO, ubeDCLO, intREQ, intPWRUP, overrun, busy;

  int checks   = 0;
  int failures = 0;
  logic [5:0] exp_q[$];

  always #5 clk = ~clk;

  ube_pwrseq #(.ACLO_DLY(16'd4), .DCLO_MIN(16'd3), .RECOVER_DLY(16'd5)) dut (
    .clk(clk), .rst(rst), .devRESET(devRESET), .csr2ACLO(csr2ACLO), .intACK(intACK),
    .ubeACLO(ubeACLO), .ubeDCLO(ubeDCLO), .intREQ(intREQ), .intPWRUP(intPWRUP),
    .overrun(overrun), .busy(busy)
  );

  // intPWRUP is only meaningful while intREQ=1 when the power-up interrupt exists.
  function automatic logic [5:0] obs(input logic [5:0] e);
    logic [5:0] g;
    g = {ubeACLO, ubeDCLO, intREQ, intPWRUP, overrun, busy};
    if (PW) g[2] = g[2] & e[3];
    return g;
  endfunction

  task automatic step(input logic csr, input logic ack, input logic dr, input logic r,
                      input logic [5:0] e);
    csr2ACLO = csr; intACK = ack; devRESET = dr; rst = r;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; devRESET = 1'b0; csr2ACLO = 1'b0; intACK = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] e, g;
    logic       tcsr[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       trst[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [5:0] texp[5] = '{6'b000000, 6'b101001, 6'b101001, 6'b000000, 6'b000000};
    for (int i = 0; i < 5; i++) begin
      step(tcsr[i], 1'b0, 1'b0, trst[i], texp[i]);
      e = exp_q.pop_front(); g = obs(e);
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL reset step=%0d got=%b exp=%b", i, g, e);
      end
    end
  endtask

  task automatic test_full_sequence();
    logic [5:0] e, g;
    int k;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      k = c + 1;
      e = {k < 26, k >= 5 && k < 21, k <= 10 || (PW && k >= 26), PW && k >= 26, 1'b0, k < 26};
      step(c < 20, c == 10 || c == 15, 1'b0, 1'b0, e);
      e = exp_q.pop_front(); g = obs(e);
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL full cycle=%0d got=%b exp=%b", k, g, e);
      end
    end
  endtask

  task automatic test_abort();
    logic [5:0] e, g;
    int k;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      k = c + 1;
      e = {k < 8, 1'b0, k <= 2 || (PW && k >= 8), PW && k >= 8, 1'b0, k < 8};
      step(c < 2, c == 2, 1'b0, 1'b0, e);
      e = exp_q.pop_front(); g = obs(e);
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL abort cycle=%0d got=%b exp=%b", k, g, e);
      end
    end
  endtask

  task automatic test_min_dclo();
    logic [5:0] e, g;
    int k;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      k = c + 1;
      e = {k < 13, k >= 5 && k < 8, k == 1 || (PW && k >= 13), PW && k >= 13, 1'b0, k < 13};
      step(c < 5, c == 1, 1'b0, 1'b0, e);
      e = exp_q.pop_front(); g = obs(e);
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL min_dclo cycle=%0d got=%b exp=%b", k, g, e);
      end
    end
  endtask

  task automatic test_overrun();
    logic [5:0] e, g;
    int k;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      k = c + 1;
      e = {k < 11, 1'b0, 1'b1, 1'b0, k >= 5, k < 11};
      step(c < 2 || c == 4, 1'b0, 1'b0, 1'b0, e);
      e = exp_q.pop_front(); g = obs(e);
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL overrun cycle=%0d got=%b exp=%b", k, g, e);
      end
    end
  endtask

  task automatic test_ack_collision();
    logic [5:0] e, g;
    int k;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      k = c + 1;
      e = {k < 11, 1'b0, 1'b1, 1'b0, PW && k >= 11, k < 11};
      step(c < 2 || c == 4, c == 4, 1'b0, 1'b0, e);
      e = exp_q.pop_front(); g = obs(e);
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL ack_collision cycle=%0d got=%b exp=%b", k, g, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] e, g;
    int k;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      k = c + 1;
      e = (k <= 6) ? {1'b1, k >= 5, 1'b1, 1'b0, 1'b0, 1'b1} : 6'b000000;
      step(c < 6, 1'b0, c == 6, 1'b0, e);
      e = exp_q.pop_front(); g = obs(e);
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL reset_mid cycle=%0d got=%b exp=%b", k, g, e);
      end
    end
  endtask

  initial begin
    rst = 1'b1; devRESET = 1'b0; csr2ACLO = 1'b0; intACK = 1'b0;
    test_reset();
    test_full_sequence();
    test_abort();
    test_min_dclo();
    test_overrun();
    test_ack_collision();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
